// File: rtl/mte_frame_feeder.sv
// mte_frame_feeder: buffers one frame of up to DEPTH bytes and replays it to the MTE core one byte per clock.
// Define MTE_FEEDER_PAD_EN to always issue DEPTH bytes, zero-padding past the true frame length.
module mte_frame_feeder #(
  parameter int DEPTH = 32,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [7:0]    key_in,
  input  logic          mode_in,
  input  logic          mte_stall,
  output logic [7:0]    mte_key,
  output logic [7:0]    mte_data,
  output logic          mte_sel,
  output logic          mte_valid,
  output logic          mte_last,
  output logic          frame_done,
  output logic [LW-1:0] frame_len,
  output logic [7:0]    frame_count
);
  typedef enum logic [1:0] {FILL, ISSUE, DONE} state_t;
  localparam logic [LW-1:0] DEPTH_M1 = LW'(DEPTH - 1);
  state_t state_q, state_d;
  logic [LW-1:0] wr_q, wr_d, rd_q, rd_d, len_q, len_d, issue_len;
  logic [7:0] key_q, key_d, data_q, data_d, cnt_q, cnt_d, rd_byte;
  logic sel_q, sel_d, valid_q, valid_d, last_q, last_d, done_q, done_d, accept;
  logic [7:0] mem_q [DEPTH];
`ifdef MTE_FEEDER_PAD_EN
  assign issue_len = LW'(DEPTH);
  assign rd_byte   = (rd_q < len_q) ? mem_q[rd_q[LW-2:0]] : 8'h00;
`else
  assign issue_len = len_q;
  assign rd_byte   = mem_q[rd_q[LW-2:0]];
`endif
  assign in_ready    = (state_q == FILL) && !reset;
  assign accept      = in_valid && in_ready;
  assign mte_key     = key_q;
  assign mte_data    = data_q;
  assign mte_sel     = sel_q;
  assign mte_valid   = valid_q;
  assign mte_last    = last_q;
  assign frame_done  = done_q;
  assign frame_len   = len_q;
  assign frame_count = cnt_q;
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    len_d   = len_q;
    key_d   = key_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = last_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: if (accept) begin
        wr_d  = wr_q + 1'b1;
        key_d = (wr_q == '0) ? key_in : key_q;
        sel_d = (wr_q == '0) ? mode_in : sel_q;
        if (in_last || wr_q == DEPTH_M1) begin
          len_d   = wr_q + 1'b1;
          rd_d    = '0;
          state_d = ISSUE;
        end
      end
      // The finishing cycle runs even under stall: no byte is presented in it.
      ISSUE: if (rd_q == issue_len) begin
        last_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = DONE;
      end else if (!mte_stall) begin
        data_d  = rd_byte;
        valid_d = 1'b1;
        last_d  = (rd_q == issue_len - 1'b1);
        rd_d    = rd_q + 1'b1;
      end
      DONE: begin
        wr_d    = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      wr_q    <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      key_q   <= '0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      key_q   <= key_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_q[LW-2:0]] <= in_data;
  end
endmodule

// File: tb/tb_mte_frame_feeder.sv
// tb_mte_frame_feeder: queue-based frame model checked every cycle, plus directed literal checks.
module tb_mte_frame_feeder;
  localparam int DEPTH = 32;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, mode_in = 1'b0, mte_stall = 1'b0;
  logic [7:0] in_data = '0, key_in = '0;
  logic in_ready, mte_sel, mte_valid, mte_last, frame_done;
  logic [7:0] mte_key, mte_data, frame_count;
  logic [LW-1:0] frame_len;
  mte_frame_feeder #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .key_in(key_in), .mode_in(mode_in), .mte_stall(mte_stall),
    .mte_key(mte_key), .mte_data(mte_data), .mte_sel(mte_sel), .mte_valid(mte_valid),
    .mte_last(mte_last), .frame_done(frame_done), .frame_len(frame_len), .frame_count(frame_count)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0, done_pulses = 0, m_len = 0;
  logic [7:0] m_fill[$], m_exp[$], log_q[$];
  logic [7:0] m_key = '0, m_data = '0, m_cnt = '0, last_byte = '0;
  logic m_ready = 1'b0, m_issuing = 1'b0, m_wait = 1'b0, m_valid = 1'b0, m_last = 1'b0;
  logic m_done = 1'b0, m_sel = 1'b0, armed = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a frame is the list of accepted bytes; once closed it drains one byte per non-stalled cycle,
  // then one cycle reports completion and one more cycle passes before input reopens.
  always @(posedge clock) begin
    if (reset) begin
      armed = 1'b1;
      m_fill.delete();
      m_exp.delete();
      {m_ready, m_issuing, m_wait, m_valid, m_last, m_done, m_sel} = 7'b1000000;
      m_key = '0; m_data = '0; m_cnt = '0; m_len = 0;
    end else if (armed) begin
      m_valid = 1'b0;
      m_done = 1'b0;
      if (m_ready) begin
        if (in_valid) begin
          if (m_fill.size() == 0) begin m_key = key_in; m_sel = mode_in; end
          m_fill.push_back(in_data);
          if (in_last || m_fill.size() == DEPTH) begin
            m_len = m_fill.size();
            m_exp = m_fill;
`ifdef MTE_FEEDER_PAD_EN
            while (m_exp.size() < DEPTH) m_exp.push_back(8'h00);
`endif
            m_fill.delete();
            m_ready = 1'b0;
            m_issuing = 1'b1;
          end
        end
      end else if (m_issuing) begin
        if (m_exp.size() == 0) begin
          m_issuing = 1'b0; m_wait = 1'b1; m_done = 1'b1; m_cnt = m_cnt + 8'd1;
        end else if (!mte_stall) begin
          m_data = m_exp.pop_front();
          m_valid = 1'b1;
          m_last = (m_exp.size() == 0);
        end
      end else if (m_wait) begin
        m_wait = 1'b0;
        m_ready = 1'b1;
      end
    end
    #1;
    if (armed) begin
      chk("in_ready", in_ready, m_ready && !reset);
      chk("mte_valid", mte_valid, m_valid);
      if (m_valid) chk("mte_last", mte_last, m_last);
      chk("mte_data", mte_data, m_data);
      chk("frame_done", frame_done, m_done);
      chk("frame_count", frame_count, m_cnt);
      chk("frame_len", frame_len, m_len);
      chk("mte_key", mte_key, m_key);
      chk("mte_sel", mte_sel, m_sel);
      if (mte_valid) log_q.push_back(mte_data);
      if (mte_valid && mte_last) last_byte = mte_data;
      if (frame_done) done_pulses++;
    end
  end
  task automatic send_byte(input logic [7:0] d, input logic l, input logic [7:0] k, input logic m);
    int t = 0;
    @(negedge clock);
    in_valid = 1'b1; in_data = d; in_last = l; key_in = k; mode_in = m;
    while (!in_ready && t < 300) begin @(negedge clock); t++; end
    chk("send_ready_wait", in_ready, 1'b1);
    @(posedge clock);
  endtask
  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_done(input int n0);
    int t = 0;
    while (done_pulses <= n0 && t < 300) begin @(negedge clock); t++; end
    chk("done_wait", done_pulses > n0, 1'b1);
    @(negedge clock);
  endtask
  task automatic wait_byte(input logic [7:0] v);
    int t = 0;
    @(negedge clock);
    while (!(mte_valid && mte_data == v) && t < 300) begin @(negedge clock); t++; end
    chk("byte_wait", mte_valid && mte_data == v, 1'b1);
  endtask
  initial begin
    int n0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_count", frame_count, 8'd0);
    chk("rst_key", mte_key, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", in_ready, 1'b1);
    log_q.delete(); n0 = done_pulses;
    for (int i = 0; i < 32; i++) send_byte(8'(i), i == 31, 8'hA5, 1'b1);
    idle(); wait_done(n0);
    chk("f32_size", log_q.size(), 32);
    chk("f32_first", log_q[0], 8'h00);
    chk("f32_byte31", log_q[31], 8'h1F);
    chk("f32_last", last_byte, 8'h1F);
    chk("f32_count", frame_count, 8'd1);
    chk("f32_len", frame_len, 32);
    chk("f32_key", mte_key, 8'hA5);
    chk("f32_sel", mte_sel, 1'b1);
    log_q.delete(); n0 = done_pulses;
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), i == 4, 8'h3C, 1'b0);
    idle(); wait_done(n0);
    chk("f5_byte4", log_q[4], 8'h15);
    chk("f5_len", frame_len, 5);
`ifdef MTE_FEEDER_PAD_EN
    chk("f5_size", log_q.size(), 32);
    chk("f5_pad", log_q[31], 8'h00);
    chk("f5_last", last_byte, 8'h00);
`else
    chk("f5_size", log_q.size(), 5);
    chk("f5_last", last_byte, 8'h15);
`endif
    log_q.delete(); n0 = done_pulses;
    for (int i = 0; i < 33; i++) send_byte(8'h40 + 8'(i), 1'b0, (i < 32) ? 8'h77 : 8'h5A, i >= 32);
    send_byte(8'h99, 1'b1, 8'h00, 1'b0);
    idle(); wait_done(n0 + 1);
    chk("auto_count", frame_count, 8'd4);
    chk("auto_b31", log_q[31], 8'h5F);
    chk("auto_b32", log_q[32], 8'h60);
    chk("auto_b33", log_q[33], 8'h99);
    chk("auto_key", mte_key, 8'h5A);
    chk("auto_sel", mte_sel, 1'b1);
    chk("auto_len", frame_len, 2);
    log_q.delete(); n0 = done_pulses;
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15, 8'h21, 1'b0);
    idle(); wait_byte(8'h07);
    mte_stall = 1'b1;
    repeat (3) @(negedge clock);
    chk("stall_hold", mte_data, 8'h07);
    chk("stall_valid", mte_valid, 1'b0);
    mte_stall = 1'b0;
    wait_done(n0);
    chk("stall_b7", log_q[7], 8'h07);
    chk("stall_b8", log_q[8], 8'h08);
    chk("stall_b15", log_q[15], 8'h0F);
    for (int i = 0; i < 20; i++) send_byte(8'(i), i == 19, 8'hE1, 1'b1);
    idle(); wait_byte(8'h0A);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", mte_valid, 1'b0);
    chk("mid_rst_data", mte_data, 8'h00);
    chk("mid_rst_len", frame_len, 0);
    chk("mid_rst_count", frame_count, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_ready", in_ready, 1'b1);
    log_q.delete(); n0 = done_pulses;
    for (int i = 0; i < 3; i++) send_byte(8'hC1 + 8'(i), i == 2, 8'h42, 1'b0);
    idle(); wait_done(n0);
    chk("f3_b0", log_q[0], 8'hC1);
    chk("f3_b2", log_q[2], 8'hC3);
`ifndef MTE_FEEDER_PAD_EN
    chk("f3_size", log_q.size(), 3);
`endif
    chk("f3_count", frame_count, 8'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n0 = done_pulses;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1'b1, 8'(i), i[0]);
      idle();
    end
    wait_done(n0 + 255);
    chk("wrap_pulses", done_pulses - n0, 256);
    chk("wrap_count", frame_count, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
